// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding and sizing.
package rst_seq_pkg;

  localparam int CNT_W      = 20;
  localparam int MAX_STAGES = 8;
  localparam int IDX_W      = 3;

  typedef enum logic [2:0] {
    LOCK_WAIT = 3'd0,
    PHY_RST   = 3'd1,
    PHY_WAIT  = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous status inputs, sync reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: shift the async input through two stages.
  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Power-up reset sequencer: waits for stable PLL lock, pulses PHY reset,
// releases downstream stage resets in order, then flags done.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned       N_STAGES     = 3,
  parameter logic [CNT_W-1:0]  LOCK_STABLE  = 20'd1000,
  parameter logic [CNT_W-1:0]  PHY_RST_CYC  = 20'd50000,
  parameter logic [CNT_W-1:0]  PHY_WAIT_CYC = 20'd100000,
  parameter logic [CNT_W-1:0]  STAGE_GAP    = 20'd16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pll_locked_i,
  input  logic                restart_i,
  output logic                phy_rstn_o,
  output logic [N_STAGES-1:0] stage_rst_o,
  output logic                done_o,
  output logic [2:0]          state_o
);

  localparam logic [CNT_W-1:0] LS_LAST  = LOCK_STABLE - CNT_W'(1);
  localparam logic [CNT_W-1:0] PR_LAST  = PHY_RST_CYC - CNT_W'(1);
  localparam logic [CNT_W-1:0] PW_LAST  = PHY_WAIT_CYC - CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LAST = STAGE_GAP - CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_STAGES - 1);

  logic lock;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               phy_rstn_q, phy_rstn_d;
  logic [N_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic               done_q, done_d;

  sync_2ff u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pll_locked_i),
    .q_o   (lock)
  );

  // Next state, counter and stage index; outputs derived from the next state
  // so that they are registered alongside it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;

    unique case (state_q)
      LOCK_WAIT: begin
        idx_d = '0;
        if (!lock || restart_i) begin
          cnt_d = '0;
        end else if (cnt_q == LS_LAST) begin
          state_d = PHY_RST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PHY_RST: begin
        if (cnt_q == PR_LAST) begin
          state_d = PHY_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PHY_WAIT: begin
        if (cnt_q == PW_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = LOCK_WAIT;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    // Lock loss or soft restart outside LOCK_WAIT aborts back to reset values.
    if (state_q != LOCK_WAIT && (!lock || restart_i)) begin
      state_d = LOCK_WAIT;
      cnt_d   = '0;
      idx_d   = '0;
    end

    phy_rstn_d = (state_d == PHY_WAIT) || (state_d == RELEASE) || (state_d == RUN);
    done_d     = (state_d == RUN);
    for (int unsigned k = 0; k < N_STAGES; k++) begin
      stage_rst_d[k] = !((state_d == RUN) ||
                         ((state_d == RELEASE) && (k <= 32'(idx_d))));
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= LOCK_WAIT;
      cnt_q       <= '0;
      idx_q       <= '0;
      phy_rstn_q  <= 1'b0;
      stage_rst_q <= '1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      phy_rstn_q  <= phy_rstn_d;
      stage_rst_q <= stage_rst_d;
      done_q      <= done_d;
    end
  end

  assign phy_rstn_o  = phy_rstn_q;
  assign stage_rst_o = stage_rst_q;
  assign done_o      = done_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: two instances (nominal and minimal parameters)
// driven with the same inputs and checked against a timeline model.
module tb_rst_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll = 1'b0;
  logic restart = 1'b0;

  logic       phy0, done0, phy1, done1;
  logic [2:0] stage0, state0, state1;
  logic [0:0] stage1;

  int vectors = 0;
  int miscompares = 0;

  // Model: t = consecutive edges with synchronized lock high and no restart.
  int   t = 0;
  int   ecnt = 0;
  logic s1m = 1'b0, s2m = 1'b0;

  logic [7:0]  obs0, exp0;
  logic [5:0]  obs1, exp1;
  logic [12:0] e0, e1;

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .N_STAGES(3), .LOCK_STABLE(20'd8), .PHY_RST_CYC(20'd4),
    .PHY_WAIT_CYC(20'd6), .STAGE_GAP(20'd3)
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .pll_locked_i(pll), .restart_i(restart),
    .phy_rstn_o(phy0), .stage_rst_o(stage0), .done_o(done0), .state_o(state0)
  );

  rst_seq_ctrl #(
    .N_STAGES(1), .LOCK_STABLE(20'd1), .PHY_RST_CYC(20'd1),
    .PHY_WAIT_CYC(20'd1), .STAGE_GAP(20'd1)
  ) dut1 (
    .clk_i(clk), .rst_i(rst), .pll_locked_i(pll), .restart_i(restart),
    .phy_rstn_o(phy1), .stage_rst_o(stage1), .done_o(done1), .state_o(state1)
  );

  // Expected outputs after t good edges: {phy, stage[7:0], done, state[2:0]}.
  function automatic logic [12:0] model_out(input int tt, input int ls, input int pr,
                                            input int pw, input int gap, input int n);
    int t2, t3, td;
    logic [7:0] st;
    logic [2:0] s;
    t2 = ls + pr;
    t3 = t2 + pw;
    td = t3 + n * gap;
    st = 8'hFF;
    for (int k = 0; k < n; k++) if (tt >= t3 + k * gap) st[k] = 1'b0;
    if (tt < ls)      s = 3'd0;
    else if (tt < t2) s = 3'd1;
    else if (tt < t3) s = 3'd2;
    else if (tt < td) s = 3'd3;
    else              s = 3'd4;
    return {(tt >= t2), st, (tt >= td), s};
  endfunction

  assign obs0 = {phy0, stage0, done0, state0};
  assign obs1 = {phy1, stage1, done1, state1};

  always_comb begin
    e0   = model_out(t, 8, 4, 6, 3, 3);
    e1   = model_out(t, 1, 1, 1, 1, 1);
    exp0 = {e0[12], e0[6:4], e0[3:0]};
    exp1 = {e1[12], e1[4], e1[3:0]};
  end

  // Drive one clock edge and advance the model; sample point is #1 later.
  task automatic step(input logic r, input logic p, input logic rs);
    rst = r; pll = p; restart = rs;
    @(posedge clk);
    if (r) begin
      t = 0; s1m = 1'b0; s2m = 1'b0; ecnt = 0;
    end else begin
      if (s2m && !rs) t++; else t = 0;
      s2m = s1m; s1m = p; ecnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      vectors++;
      if (obs0 !== 8'b0_111_0_000) begin
        miscompares++;
        $display("FAIL reset dut0: got %b want %b", obs0, 8'b0_111_0_000);
      end
      vectors++;
      if (obs1 !== 6'b0_1_0_000) begin
        miscompares++;
        $display("FAIL reset dut1: got %b want %b", obs1, 6'b0_1_0_000);
      end
    end
  endtask

  task automatic test_nominal();
    logic [7:0] want;
    logic chk;
    for (int i = 0; i < 39; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk = 1'b1;
      case (ecnt)
        13: want = 8'b0_111_0_001;
        14: want = 8'b1_111_0_010;
        20: want = 8'b1_110_0_011;
        23: want = 8'b1_100_0_011;
        26: want = 8'b1_000_0_011;
        28: want = 8'b1_000_0_011;
        29: want = 8'b1_000_1_100;
        default: begin want = '0; chk = 1'b0; end
      endcase
      if (chk) begin
        vectors++;
        if (obs0 !== want) begin
          miscompares++;
          $display("FAIL nominal_timeline edge %0d: got %b want %b", ecnt, obs0, want);
        end
      end
      vectors++;
      if (obs0 !== exp0) begin
        miscompares++;
        $display("FAIL nominal dut0 edge %0d: got %b want %b", ecnt, obs0, exp0);
      end
      vectors++;
      if (obs1 !== exp1) begin
        miscompares++;
        $display("FAIL nominal dut1 edge %0d: got %b want %b", ecnt, obs1, exp1);
      end
    end
  endtask

  // Continues from the nominal run (ecnt = 39): lock drops at edge 40..44.
  task automatic test_lock_loss();
    logic [7:0] want;
    logic chk;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, !((ecnt + 1 >= 40) && (ecnt + 1 <= 44)), 1'b0);
      chk = 1'b1;
      case (ecnt)
        41: want = 8'b1_000_1_100;
        42: want = 8'b0_111_0_000;
        57: want = 8'b0_111_0_001;
        58: want = 8'b1_111_0_010;
        default: begin want = '0; chk = 1'b0; end
      endcase
      if (chk) begin
        vectors++;
        if (obs0 !== want) begin
          miscompares++;
          $display("FAIL lock_loss_timeline edge %0d: got %b want %b", ecnt, obs0, want);
        end
      end
      vectors++;
      if (obs0 !== exp0) begin
        miscompares++;
        $display("FAIL lock_loss dut0 edge %0d: got %b want %b", ecnt, obs0, exp0);
      end
      vectors++;
      if (obs1 !== exp1) begin
        miscompares++;
        $display("FAIL lock_loss dut1 edge %0d: got %b want %b", ecnt, obs1, exp1);
      end
    end
  endtask

  // Lock high for edges 1..5, low at edge 6, high afterwards.
  task automatic test_lock_glitch();
    logic [7:0] want;
    logic chk;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, (ecnt + 1 != 6), 1'b0);
      chk = 1'b1;
      case (ecnt)
        19: want = 8'b0_111_0_001;
        20: want = 8'b1_111_0_010;
        35: want = 8'b1_000_1_100;
        default: begin want = '0; chk = 1'b0; end
      endcase
      if (chk) begin
        vectors++;
        if (obs0 !== want) begin
          miscompares++;
          $display("FAIL glitch_timeline edge %0d: got %b want %b", ecnt, obs0, want);
        end
      end
      vectors++;
      if (obs0 !== exp0) begin
        miscompares++;
        $display("FAIL glitch dut0 edge %0d: got %b want %b", ecnt, obs0, exp0);
      end
      vectors++;
      if (obs1 !== exp1) begin
        miscompares++;
        $display("FAIL glitch dut1 edge %0d: got %b want %b", ecnt, obs1, exp1);
      end
    end
  endtask

  // Soft restart pulsed at edge 21, right after stage 0 is released.
  task automatic test_restart();
    logic [7:0] want;
    logic chk;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 55; i++) begin
      step(1'b0, 1'b1, (ecnt + 1 == 21));
      chk = 1'b1;
      case (ecnt)
        20: want = 8'b1_110_0_011;
        21: want = 8'b0_111_0_000;
        32: want = 8'b0_111_0_001;
        33: want = 8'b1_111_0_010;
        47: want = 8'b1_000_0_011;
        48: want = 8'b1_000_1_100;
        default: begin want = '0; chk = 1'b0; end
      endcase
      if (chk) begin
        vectors++;
        if (obs0 !== want) begin
          miscompares++;
          $display("FAIL restart_timeline edge %0d: got %b want %b", ecnt, obs0, want);
        end
      end
      vectors++;
      if (obs0 !== exp0) begin
        miscompares++;
        $display("FAIL restart dut0 edge %0d: got %b want %b", ecnt, obs0, exp0);
      end
    end
  endtask

  // rst and restart together during PHY_WAIT, then rerun the nominal timeline.
  task automatic test_reset_priority();
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0);
    vectors++;
    if (obs0 !== 8'b1_111_0_010) begin
      miscompares++;
      $display("FAIL prio_phy_wait: got %b want %b", obs0, 8'b1_111_0_010);
    end
    step(1'b1, 1'b1, 1'b1);
    vectors++;
    if (obs0 !== 8'b0_111_0_000) begin
      miscompares++;
      $display("FAIL prio_reset dut0: got %b want %b", obs0, 8'b0_111_0_000);
    end
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (ecnt == 14 || ecnt == 29) begin
        vectors++;
        if (obs0 !== ((ecnt == 14) ? 8'b1_111_0_010 : 8'b1_000_1_100)) begin
          miscompares++;
          $display("FAIL prio_timeline edge %0d: got %b", ecnt, obs0);
        end
      end
      vectors++;
      if (obs0 !== exp0) begin
        miscompares++;
        $display("FAIL prio dut0 edge %0d: got %b want %b", ecnt, obs0, exp0);
      end
    end
  endtask

  // Minimal-parameter instance: one cycle per state.
  task automatic test_edge_params();
    logic [5:0] want;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0);
      case (ecnt)
        1, 2:    want = 6'b0_1_0_000;
        3:       want = 6'b0_1_0_001;
        4:       want = 6'b1_1_0_010;
        5:       want = 6'b1_0_0_011;
        default: want = 6'b1_0_1_100;
      endcase
      vectors++;
      if (obs1 !== want) begin
        miscompares++;
        $display("FAIL edge_params dut1 edge %0d: got %b want %b", ecnt, obs1, want);
      end
    end
  endtask

  // Random lock drops, restarts and resets against the model.
  task automatic test_random();
    int r;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      step((r == 6), !(r < 4), (r == 4 || r == 5));
      vectors++;
      if (obs0 !== exp0) begin
        miscompares++;
        $display("FAIL random dut0 cycle %0d: got %b want %b", i, obs0, exp0);
      end
      vectors++;
      if (obs1 !== exp1) begin
        miscompares++;
        $display("FAIL random dut1 cycle %0d: got %b want %b", i, obs1, exp1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss();
    test_lock_glitch();
    test_restart();
    test_reset_priority();
    test_edge_params();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Power-up and reset sequencer for the PLL/ADC/Ethernet capture design. It waits for the PLL lock to be stable, then pulses the Ethernet PHY hardware reset. It then releases downstream block resets (e.g. ADC capture, MAC, loop logic) one at a time with fixed spacing, and flags completion. It sits directly after the clock generator and replaces ad-hoc fixed-delay reset generators.

Parameters:
N_STAGES, 3, number of downstream stage resets released in order; legal range 1..8.
LOCK_STABLE, 20'd1000, cycles the synchronized lock must stay high before sequencing starts; must be at least 1.
PHY_RST_CYC, 20'd50000, cycles phy_rstn_o is held low in the PHY_RST state; must be at least 1.
PHY_WAIT_CYC, 20'd100000, cycles to wait after PHY reset release before stage 0 is released; must be at least 1.
STAGE_GAP, 20'd16, cycles between successive stage releases, and between the last stage release and done_o; must be at least 1.

Ports:
clk_i  in  1  system clock; all logic is on its rising edge.
rst_i  in  1  synchronous reset, active-high.
pll_locked_i  in  1  PLL lock, asynchronous to clk_i.
restart_i  in  1  synchronous soft restart; sampled each cycle, and a high level restarts the sequence.
phy_rstn_o  out  1  Ethernet PHY reset, active-low.
stage_rst_o  out  N_STAGES  per-stage reset, active-high; bit k is released k-th.
done_o  out  1  high once all stages are released and lock is held.
state_o  out  3  current state encoding, for debug.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high, and it dominates every other input.
- Reset values:
  - state = LOCK_WAIT, cnt = 0, stage index = 0
  - phy_rstn_o = 0, stage_rst_o = all 1s, done_o = 0
  - both lock synchronizer flops = 0
- Lock synchronizer: pll_locked_i passes through a 2-flop synchronizer, giving 2 cycles of latency. "lock" below always means the synchronized value.
- Outputs: all outputs are registered and are a function of the state and stage index only.
- Counter: a single 20-bit cnt. On entering any state, cnt = 0. While in a state, each cycle either transitions (when cnt == LIMIT-1) or does cnt + 1. A state therefore lasts exactly LIMIT cycles. cnt never wraps.
- States:
  - LOCK_WAIT (0): outputs at reset values. When lock is low, cnt = 0. When lock is high, count. At cnt == LOCK_STABLE-1, go to PHY_RST.
  - PHY_RST (1): phy_rstn_o = 0. At cnt == PHY_RST_CYC-1, go to PHY_WAIT; phy_rstn_o becomes 1 on that edge.
  - PHY_WAIT (2): phy_rstn_o = 1. At cnt == PHY_WAIT_CYC-1, go to RELEASE with index = 0; stage_rst_o[0] becomes 0 on that edge.
  - RELEASE (3): at cnt == STAGE_GAP-1:
    - if index < N_STAGES-1: index + 1, stage_rst_o[index+1] becomes 0, cnt = 0;
    - else: go to RUN; done_o becomes 1 on that edge.
    Once a stage is released it stays released.
  - RUN (4): hold all outputs; cnt is idle.
- Abort: if lock is low or restart_i is high in any state other than LOCK_WAIT, the next edge goes to LOCK_WAIT. All outputs and counters return to reset values on that same edge.
- Restart in LOCK_WAIT: restart_i high there clears cnt.
- Glitch filtering: a lock drop of 1 cycle (after synchronization) is enough to abort. Because LOCK_WAIT clears cnt whenever lock is low, lock glitches during LOCK_WAIT also restart the stability count.
- Output invariants:
  - stage_rst_o never releases a bit while phy_rstn_o = 0.
  - done_o = 1 implies stage_rst_o = 0.
- Unused encodings 5..7 go to LOCK_WAIT with reset outputs.

Decomposition:
- Shared package rst_seq_pkg holds:
  - the state encoding constants (LOCK_WAIT = 3'd0 … RUN = 3'd4);
  - CNT_W = 20;
  - MAX_STAGES = 8.
- One sub-module, sync_2ff: a 1-bit two-flop synchronizer with synchronous active-high reset to 0. Instantiate it for pll_locked_i. It is reusable for other asynchronous status inputs.

Test Plan:
Use LOCK_STABLE=8, PHY_RST_CYC=4, PHY_WAIT_CYC=6, STAGE_GAP=3, N_STAGES=3. Edge 1 is the first rising edge with rst_i low.
1. Nominal sequence: pll_locked_i held high through and after reset → phy_rstn_o rises after edge 14; stage_rst_o goes to 3'b110 after edge 20, 3'b100 after edge 23, 3'b000 after edge 26; done_o rises after edge 29; state_o reads 4 thereafter.
2. Unstable lock: pll_locked_i low for 1 cycle, 5 cycles after lock first rises → LOCK_WAIT count restarts; phy_rstn_o rise is delayed by exactly (5 + glitch width) cycles versus scenario 1.
3. Lock loss in RUN: pll_locked_i drops at edge 40 → 2 synchronizer cycles later, the next edge gives phy_rstn_o = 0, stage_rst_o = 3'b111, done_o = 0, state_o = 0. Re-lock reproduces the scenario 1 timeline relative to the re-lock.
4. Soft restart mid-RELEASE: restart_i pulsed 1 cycle right after stage 0 is released → next edge restores all reset outputs and state LOCK_WAIT; the sequence reruns with the same cycle counts.
5. Reset priority: rst_i and restart_i both high, with lock high during PHY_WAIT → reset values result; release of rst_i gives the scenario 1 timeline.
6. Edge parameters: N_STAGES=1 and all LIMITs = 1 → state visits every state with 1 cycle each; stage_rst_o[0] is released one edge after phy_rstn_o rises, and done_o follows 1 edge later.
